// File: rtl/pipeline_pkg.sv
// Shared pipeline types: multicycle-unit FSM state encoding and the default watchdog limit.
package pipeline_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } md_state_t;

    localparam int MDU_MAX_CYCLES_DEFAULT = 64;

endpackage

// File: rtl/md_stall_fsm.sv
// Multicycle MUL/DIV stall controller: IDLE/BUSY FSM, BUSY-cycle counter and sticky watchdog.
module md_stall_fsm
    import pipeline_pkg::*;
#(
    parameter int MAX_CYCLES = MDU_MAX_CYCLES_DEFAULT
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      start,
    input  logic      done,
    output md_state_t state,
    output logic      stall,
    output logic      timeout
);

    localparam int            CW   = (MAX_CYCLES > 2) ? $clog2(MAX_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(MAX_CYCLES - 1);

    md_state_t     state_next;
    logic [CW-1:0] cnt;
    logic          expire;

    always_comb begin
        state_next = state;
        stall      = 1'b0;
        expire     = 1'b0;
        case (state)
            IDLE: begin
                if (start && !done) begin
                    stall      = 1'b1;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                // A result arriving on the last allowed cycle still counts as success.
                if (done) begin
                    state_next = IDLE;
                end else if (cnt == LAST) begin
                    expire     = 1'b1;
                    state_next = IDLE;
                end else begin
                    stall = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            timeout <= 1'b0;
        end else begin
            state <= state_next;
            if (state == BUSY && state_next == BUSY) begin
                cnt <= cnt + 1'b1;
            end else begin
                cnt <= '0;
            end
            if (expire) begin
                timeout <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: load-use stall, branch flush and multicycle-op stall arbitration.
// Optional HAZARD_PERF_EN adds 32-bit stall/flush cycle counters.
module hazard_unit
    import pipeline_pkg::*;
#(
    parameter int MDU_MAX_CYCLES = MDU_MAX_CYCLES_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  Rs1D,
    input  logic [4:0]  Rs2D,
    input  logic [4:0]  RdE,
    input  logic        LoadE,
    input  logic        PCSrcE,
    input  logic        MdStartE,
    input  logic        MdDoneE,
    output logic        StallF,
    output logic        StallD,
    output logic        StallE,
    output logic        FlushD,
    output logic        FlushE,
    output logic        FlushM,
    output logic        MdBusy,
    output logic        MdTimeout,
    output logic [31:0] StallCycles,
    output logic [31:0] FlushCycles
);

    md_state_t md_state;
    logic      md_stall;
    logic      load_use;

    md_stall_fsm #(
        .MAX_CYCLES (MDU_MAX_CYCLES)
    ) u_md_fsm (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (MdStartE),
        .done    (MdDoneE),
        .state   (md_state),
        .stall   (md_stall),
        .timeout (MdTimeout)
    );

    assign MdBusy   = (md_state == BUSY);
    assign load_use = LoadE && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));

    // Priority: reset, then the multicycle op, then the branch flush (which already
    // squashes the load-use consumer), then the load-use bubble.
    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        FlushM = 1'b0;
        if (!rst_n) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
            FlushM = 1'b1;
        end else if (MdBusy || md_stall) begin
            StallF = md_stall;
            StallD = md_stall;
            StallE = md_stall;
            FlushM = md_stall;
        end else if (PCSrcE) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
        end else if (load_use) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (StallF) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (FlushD || FlushE || FlushM) begin
                flush_cnt <= flush_cnt + 32'd1;
            end
        end
    end

    assign StallCycles = stall_cnt;
    assign FlushCycles = flush_cnt;
`else
    assign StallCycles = 32'd0;
    assign FlushCycles = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed scenarios plus randomized traffic against a cycle model.
module tb_hazard_unit;

    localparam int MAXC = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  Rs1D, Rs2D, RdE;
    logic        LoadE, PCSrcE, MdStartE, MdDoneE;
    logic        StallF, StallD, StallE, FlushD, FlushE, FlushM, MdBusy, MdTimeout;
    logic [31:0] StallCycles, FlushCycles;
    logic [7:0]  obs;

    int checks = 0;
    int errors = 0;

    // Reference model state: is an op outstanding, how long, and the sticky error.
    bit          m_busy;
    int          m_elapsed;
    bit          m_timeout;
    logic [31:0] m_stall_cnt;
    logic [31:0] m_flush_cnt;

    hazard_unit #(
        .MDU_MAX_CYCLES (MAXC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .Rs1D        (Rs1D),
        .Rs2D        (Rs2D),
        .RdE         (RdE),
        .LoadE       (LoadE),
        .PCSrcE      (PCSrcE),
        .MdStartE    (MdStartE),
        .MdDoneE     (MdDoneE),
        .StallF      (StallF),
        .StallD      (StallD),
        .StallE      (StallE),
        .FlushD      (FlushD),
        .FlushE      (FlushE),
        .FlushM      (FlushM),
        .MdBusy      (MdBusy),
        .MdTimeout   (MdTimeout),
        .StallCycles (StallCycles),
        .FlushCycles (FlushCycles)
    );

    always #5 clk = ~clk;

    // {StallF, StallD, StallE, FlushD, FlushE, FlushM, MdBusy, MdTimeout}
    assign obs = {StallF, StallD, StallE, FlushD, FlushE, FlushM, MdBusy, MdTimeout};

    function automatic logic [7:0] model_out();
        logic sf, sd, se, fd, fe, fm, hit;
        hit = LoadE && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));
        {sf, sd, se, fd, fe, fm} = 6'b0;
        if (!rst_n) begin
            {fd, fe, fm} = 3'b111;
        end else if (m_busy) begin
            if (!MdDoneE && m_elapsed < MAXC - 1) {sf, sd, se, fm} = 4'hF;
        end else if (MdStartE && !MdDoneE) begin
            {sf, sd, se, fm} = 4'hF;
        end else if (PCSrcE) begin
            {fd, fe} = 2'b11;
        end else if (hit) begin
            {sf, sd, fe} = 3'b111;
        end
        return {sf, sd, se, fd, fe, fm, m_busy, m_timeout};
    endfunction

    function automatic logic [31:0] exp_stall_cnt();
`ifdef HAZARD_PERF_EN
        return m_stall_cnt;
`else
        return 32'd0;
`endif
    endfunction

    function automatic logic [31:0] exp_flush_cnt();
`ifdef HAZARD_PERF_EN
        return m_flush_cnt;
`else
        return 32'd0;
`endif
    endfunction

    task automatic model_step();
        logic [7:0] e;
        e = model_out();
        if (!rst_n) begin
            m_busy      = 1'b0;
            m_elapsed   = 0;
            m_timeout   = 1'b0;
            m_stall_cnt = '0;
            m_flush_cnt = '0;
        end else begin
            if (e[7]) m_stall_cnt = m_stall_cnt + 32'd1;
            if (|e[4:2]) m_flush_cnt = m_flush_cnt + 32'd1;
            if (m_busy) begin
                if (MdDoneE) begin
                    m_busy = 1'b0;
                end else if (m_elapsed == MAXC - 1) begin
                    m_busy    = 1'b0;
                    m_timeout = 1'b1;
                end else begin
                    m_elapsed++;
                end
            end else if (MdStartE && !MdDoneE) begin
                m_busy    = 1'b1;
                m_elapsed = 0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic drive(input logic r, input logic st, input logic dn, input logic ld, input logic pc);
        rst_n    = r;
        MdStartE = st;
        MdDoneE  = dn;
        LoadE    = ld;
        PCSrcE   = pc;
    endtask

    task automatic test_reset();
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        RdE = 5'd7; Rs1D = 5'd7; Rs2D = 5'd0;
        tick();
        tick();
        @(negedge clk);
        checks++;
        if (obs !== 8'b00011100) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected %b", obs, 8'b00011100);
        end
        tick();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (obs !== 8'b00000000) begin
            errors++;
            $display("FAIL reset_release_idle: got %b expected %b", obs, 8'b00000000);
        end
        checks++;
        if (StallCycles !== 32'd0 || FlushCycles !== 32'd0) begin
            errors++;
            $display("FAIL reset_counters: got %0d/%0d expected 0/0", StallCycles, FlushCycles);
        end
        tick();
    endtask

    task automatic test_load_use();
        logic [4:0] rd_t[5]  = '{5'd5, 5'd5, 5'd0, 5'd5, 5'd5};
        logic [4:0] rs1_t[5] = '{5'd5, 5'd3, 5'd0, 5'd5, 5'd4};
        logic [4:0] rs2_t[5] = '{5'd0, 5'd5, 5'd0, 5'd5, 5'd6};
        logic       ld_t[5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [7:0] exp_t[5] = '{8'b11001000, 8'b11001000, 8'b00000000, 8'b00000000, 8'b00000000};
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, 1'b0, ld_t[i], 1'b0);
            RdE = rd_t[i]; Rs1D = rs1_t[i]; Rs2D = rs2_t[i];
            @(negedge clk);
            checks++;
            if (obs !== exp_t[i]) begin
                errors++;
                $display("FAIL load_use_%0d: got %b expected %b", i, obs, exp_t[i]);
            end
            tick();
        end
    endtask

    task automatic test_branch();
        logic       ld_t[3]  = '{1'b0, 1'b1, 1'b0};
        logic       pc_t[3]  = '{1'b1, 1'b1, 1'b0};
        logic [7:0] exp_t[3] = '{8'b00011000, 8'b00011000, 8'b00000000};
        RdE = 5'd5; Rs1D = 5'd5; Rs2D = 5'd1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 1'b0, ld_t[i], pc_t[i]);
            @(negedge clk);
            checks++;
            if (obs !== exp_t[i]) begin
                errors++;
                $display("FAIL branch_%0d: got %b expected %b", i, obs, exp_t[i]);
            end
            tick();
        end
    endtask

    task automatic test_mdu_multi();
        // {start, done, load, pcsrc} per cycle; load/branch during BUSY must be ignored
        logic [3:0] in_t[6]  = '{4'b1000, 4'b1000, 4'b1011, 4'b1000, 4'b1100, 4'b0000};
        logic [7:0] exp_t[6] = '{8'b11100100, 8'b11100110, 8'b11100110,
                                 8'b11100110, 8'b00000010, 8'b00000000};
        RdE = 5'd5; Rs1D = 5'd5; Rs2D = 5'd0;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, in_t[i][3], in_t[i][2], in_t[i][1], in_t[i][0]);
            @(negedge clk);
            checks++;
            if (obs !== exp_t[i]) begin
                errors++;
                $display("FAIL mdu_multi_c%0d: got %b expected %b", i, obs, exp_t[i]);
            end
            tick();
        end
    endtask

    task automatic test_mdu_single();
        logic [3:0] in_t[3]  = '{4'b1100, 4'b0000, 4'b1110};
        logic [7:0] exp_t[3] = '{8'b00000000, 8'b00000000, 8'b11001000};
        RdE = 5'd9; Rs1D = 5'd2; Rs2D = 5'd9;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, in_t[i][3], in_t[i][2], in_t[i][1], in_t[i][0]);
            @(negedge clk);
            checks++;
            if (obs !== exp_t[i]) begin
                errors++;
                $display("FAIL mdu_single_%0d: got %b expected %b", i, obs, exp_t[i]);
            end
            tick();
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_timeout();
        logic [7:0] e;
        RdE = 5'd3; Rs1D = 5'd3; Rs2D = 5'd0;
        for (int k = 0; k < 15; k++) begin
            drive(k >= 13 ? 1'b0 : 1'b1, (k < 8) ? 1'b1 : 1'b0, 1'b0, (k == 10) ? 1'b1 : 1'b0, 1'b0);
            if (k == 0)                 e = 8'b11100100;
            else if (k < 8)             e = 8'b11100110;
            else if (k == 8)            e = 8'b00000010;
            else if (k == 10)           e = 8'b11001001;
            else if (k < 13)            e = 8'b00000001;
            else if (k == 13)           e = 8'b00011101;
            else                        e = 8'b00011100;
            @(negedge clk);
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL timeout_c%0d: got %b expected %b", k, obs, e);
            end
            tick();
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (MdTimeout !== 1'b0) begin
            errors++;
            $display("FAIL timeout_cleared: got %b expected 0", MdTimeout);
        end
        tick();
    endtask

    task automatic test_reset_busy();
        logic [7:0] exp_t[4] = '{8'b11100100, 8'b11100110, 8'b00011110, 8'b00000000};
        logic       rst_t[4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        logic       st_t[4]  = '{1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            drive(rst_t[i], st_t[i], 1'b0, 1'b0, 1'b0);
            @(negedge clk);
            checks++;
            if (obs !== exp_t[i]) begin
                errors++;
                $display("FAIL reset_busy_c%0d: got %b expected %b", i, obs, exp_t[i]);
            end
            tick();
        end
        checks++;
        if (StallCycles !== 32'd0 || FlushCycles !== 32'd1 * exp_flush_cnt()) begin
            errors++;
            $display("FAIL reset_busy_counters: got %0d/%0d expected 0/%0d",
                     StallCycles, FlushCycles, exp_flush_cnt());
        end
    endtask

    task automatic test_perf_counters();
        @(negedge clk);
        checks++;
        if (StallCycles !== exp_stall_cnt() || FlushCycles !== exp_flush_cnt()) begin
            errors++;
            $display("FAIL perf_counters: got %0d/%0d expected %0d/%0d",
                     StallCycles, FlushCycles, exp_stall_cnt(), exp_flush_cnt());
        end
        tick();
    endtask

    task automatic test_random();
        logic [7:0] e;
        for (int n = 0; n < 3000; n++) begin
            rst_n    = ($urandom_range(0, 199) != 0);
            RdE      = 5'($urandom_range(0, 3));
            Rs1D     = 5'($urandom_range(0, 3));
            Rs2D     = 5'($urandom_range(0, 3));
            LoadE    = 1'($urandom_range(0, 1));
            PCSrcE   = ($urandom_range(0, 3) == 0);
            MdStartE = ($urandom_range(0, 7) == 0);
            MdDoneE  = ($urandom_range(0, 5) == 0);
            @(negedge clk);
            e = model_out();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL random_outputs n=%0d: got %b expected %b", n, obs, e);
            end
            checks++;
            if (StallCycles !== exp_stall_cnt() || FlushCycles !== exp_flush_cnt()) begin
                errors++;
                $display("FAIL random_counters n=%0d: got %0d/%0d expected %0d/%0d",
                         n, StallCycles, FlushCycles, exp_stall_cnt(), exp_flush_cnt());
            end
            tick();
        end
    endtask

    initial begin
        rst_n = 1'b0;
        {Rs1D, Rs2D, RdE} = '0;
        {LoadE, PCSrcE, MdStartE, MdDoneE} = '0;
        m_busy = 1'b0; m_elapsed = 0; m_timeout = 1'b0;
        m_stall_cnt = '0; m_flush_cnt = '0;

        test_reset();
        test_load_use();
        test_branch();
        test_mdu_multi();
        test_mdu_single();
        test_perf_counters();
        test_timeout();
        test_reset_busy();
        test_random();
        test_perf_counters();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
